// File: rtl/event_counter_unit_if.sv
// rtl/event_counter_unit_if.sv - event pulse bundle feeding the event counter unit
interface EVENT_INT;
    logic load;
    logic store;
    logic unaligned;
    logic arithmetic;
    logic trap;
    logic interrupt;
    logic conditional_branch;
    logic unconditional_branch;
    logic branch;
    logic execute;

    modport in (
        input load, store, unaligned, arithmetic, trap, interrupt,
              conditional_branch, unconditional_branch, branch, execute
    );
    modport out (
        output load, store, unaligned, arithmetic, trap, interrupt,
               conditional_branch, unconditional_branch, branch, execute
    );
endinterface

// File: rtl/event_counter_unit.sv
// rtl/event_counter_unit.sv - four selectable 32-bit event counters with a req/ack register port
// Optional overflow interrupt mask at addr 10 enabled by EVENT_COUNTER_OVF_IRQ_EN.
module event_counter_unit (
    input  logic        clk,
    input  logic        rst,
    EVENT_INT.in        events,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0][31:0]  cnt_q, cnt_d;
    logic [3:0][3:0]   sel_q, sel_d;
    logic [3:0]        inh_q, inh_d;
    logic [3:0]        ovf_q, ovf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       ev_vec;
    logic [3:0]        hit;
    logic [3:0]        wrap;
    logic [3:0]        ovf_clr;
    logic [31:0]       rd_mux;
    logic              accept;
    logic              wr_en;

    // Indices 10-15 are hard zero so a selector of 4'hF never counts.
    assign ev_vec = {6'b0,
                     events.execute,
                     events.branch,
                     events.unconditional_branch,
                     events.conditional_branch,
                     events.interrupt,
                     events.trap,
                     events.arithmetic,
                     events.unaligned,
                     events.store,
                     events.load};

    assign accept = (state_q == S_IDLE) && req;
    assign wr_en  = accept && we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A bus write to a counter wins over a same-cycle event, so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        hit   = '0;
        wrap  = '0;
        for (int n = 0; n < 4; n++) begin
            hit[n] = ev_vec[sel_q[n]] & ~inh_q[n];
            if (wr_en && (addr == 4'(n))) begin
                cnt_d[n] = wdata;
            end else if (hit[n]) begin
                cnt_d[n] = cnt_q[n] + 32'd1;
                wrap[n]  = &cnt_q[n];
            end
        end
    end

    // Wrap set is OR'ed after the W1C clear so a coincident set survives.
    always_comb begin
        ovf_clr = (wr_en && (addr == 4'd9)) ? wdata[3:0] : 4'b0;
        ovf_d   = (ovf_q & ~ovf_clr) | wrap;
    end

    always_comb begin
        sel_d = sel_q;
        inh_d = inh_q;
        if (wr_en) begin
            case (addr)
                4'd4:    sel_d[0] = wdata[3:0];
                4'd5:    sel_d[1] = wdata[3:0];
                4'd6:    sel_d[2] = wdata[3:0];
                4'd7:    sel_d[3] = wdata[3:0];
                4'd8:    inh_d    = wdata[3:0];
                default: ;
            endcase
        end
    end

`ifdef EVENT_COUNTER_OVF_IRQ_EN
    logic [3:0] msk_q, msk_d;
    logic       irq_q;

    always_comb begin
        msk_d = msk_q;
        if (wr_en && (addr == 4'd10)) msk_d = wdata[3:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msk_q <= 4'b0;
            irq_q <= 1'b0;
        end else begin
            msk_q <= msk_d;
            irq_q <= |(ovf_q & msk_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Reads see the registered counter, i.e. the value before this cycle's increment.
    always_comb begin
        rd_mux = 32'b0;
        case (addr)
            4'd0:    rd_mux = cnt_q[0];
            4'd1:    rd_mux = cnt_q[1];
            4'd2:    rd_mux = cnt_q[2];
            4'd3:    rd_mux = cnt_q[3];
            4'd4:    rd_mux = {28'b0, sel_q[0]};
            4'd5:    rd_mux = {28'b0, sel_q[1]};
            4'd6:    rd_mux = {28'b0, sel_q[2]};
            4'd7:    rd_mux = {28'b0, sel_q[3]};
            4'd8:    rd_mux = {28'b0, inh_q};
            4'd9:    rd_mux = {28'b0, ovf_q};
`ifdef EVENT_COUNTER_OVF_IRQ_EN
            4'd10:   rd_mux = {28'b0, msk_q};
`endif
            default: rd_mux = 32'b0;
        endcase
    end

    assign rdata_d = (accept && !we) ? rd_mux : 32'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= {4{4'hF}};
            inh_q   <= 4'b0;
            ovf_q   <= 4'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            inh_q   <= inh_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack   = (state_q == S_ACK);
    assign rdata = rdata_q;

endmodule
